// File: rtl/rambus_arb_pkg.sv
// ---------------------------------------------------------------------------
// rambus_arb_pkg
//   Shared definitions for the rambus arbiter: arbiter state encoding, the
//   Wishbone field widths of the OpenRAM wrapper rambus port, and a helper
//   that sizes master-index fields.
//   No ports (package).
// ---------------------------------------------------------------------------
package rambus_arb_pkg;

    localparam int RAMBUS_DATA_W = 32;
    localparam int RAMBUS_SEL_W  = 4;
    localparam int RAMBUS_ADDR_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_e;

    // Width of an index that can address n masters (at least one bit).
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// ---------------------------------------------------------------------------
// rr_priority_pick
//   Combinational round-robin picker. Searches the request vector starting
//   one position after the last-served index and wrapping around, so the
//   last-served requester has the lowest priority.
//   Ports:
//     req_i    in   N        request vector
//     last_i   in   idx_w(N) index of the last-served requester
//     valid_o  out  1        at least one request is pending
//     index_o  out  idx_w(N) winning requester (0 when valid_o is low)
// ---------------------------------------------------------------------------
module rr_priority_pick
    import rambus_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]        req_i,
    input  logic [idx_w(N)-1:0] last_i,
    output logic                valid_o,
    output logic [idx_w(N)-1:0] index_o
);

    localparam int IW = idx_w(N);

    // NOTE: every signal written here gets a default before any condition;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        int cand;
        valid_o = 1'b0;
        index_o = '0;
        cand    = 0;
        for (int k = 1; k <= N; k++) begin
            cand = (int'(last_i) + k) % N;
            if (!valid_o && req_i[IW'(cand)]) begin
                valid_o = 1'b1;
                index_o = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/wb_rambus_arbiter.sv
// ---------------------------------------------------------------------------
// wb_rambus_arbiter
//   Round-robin Wishbone arbiter sharing the single rambus port (port B) of
//   the OpenRAM wishbone wrapper among NUM_MASTERS user-project masters.
//   A grant is held for a whole Wishbone cycle (cyc high); one IDLE cycle
//   always separates two grants.
//   Compile-time option: RAMBUS_ARB_TIMEOUT_EN adds a stalled-strobe counter
//   that aborts a cycle after TIMEOUT_CYCLES stalled cycles, pulsing
//   m_err_o for the granted master and passing through RELEASE.
//   Ports:
//     wb_clk_i, wb_rst_i            clock, synchronous active-high reset
//     m_cyc/stb/we/sel/dat/adr_i    packed per-master request buses
//     m_ack_o, m_err_o, m_dat_o     per-master responses (0 unless granted)
//     s_wb_clk_o, s_wb_rst_o        clock/reset forwarded to the wrapper
//     s_cyc/stb/we/sel/dat/adr_o    muxed request to the wrapper slave port
//     s_ack_i, s_dat_i              slave response
// ---------------------------------------------------------------------------
module wb_rambus_arbiter
    import rambus_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_W         = RAMBUS_ADDR_W,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                 wb_clk_i,
    input  logic                                 wb_rst_i,
    input  logic [NUM_MASTERS-1:0]               m_cyc_i,
    input  logic [NUM_MASTERS-1:0]               m_stb_i,
    input  logic [NUM_MASTERS-1:0]               m_we_i,
    input  logic [RAMBUS_SEL_W*NUM_MASTERS-1:0]  m_sel_i,
    input  logic [RAMBUS_DATA_W*NUM_MASTERS-1:0] m_dat_i,
    input  logic [ADDR_W*NUM_MASTERS-1:0]        m_adr_i,
    output logic [NUM_MASTERS-1:0]               m_ack_o,
    output logic [NUM_MASTERS-1:0]               m_err_o,
    output logic [RAMBUS_DATA_W*NUM_MASTERS-1:0] m_dat_o,
    output logic                                 s_wb_clk_o,
    output logic                                 s_wb_rst_o,
    output logic                                 s_cyc_o,
    output logic                                 s_stb_o,
    output logic                                 s_we_o,
    output logic [RAMBUS_SEL_W-1:0]              s_sel_o,
    output logic [RAMBUS_DATA_W-1:0]             s_dat_o,
    output logic [ADDR_W-1:0]                    s_adr_o,
    input  logic                                 s_ack_i,
    input  logic [RAMBUS_DATA_W-1:0]             s_dat_i
);

    localparam int IW = idx_w(NUM_MASTERS);

    arb_state_e      state_q, state_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic [IW-1:0]   last_q,  last_d;
    logic            pick_valid;
    logic [IW-1:0]   pick_idx;
    logic            busy_stb;
    logic            timeout_hit;

    assign s_wb_clk_o = wb_clk_i;
    assign s_wb_rst_o = wb_rst_i;

    // Only cyc requests arbitration; a strobe without cyc is ignored.
    rr_priority_pick #(.N(NUM_MASTERS)) u_pick (
        .req_i   (m_cyc_i),
        .last_i  (last_q),
        .valid_o (pick_valid),
        .index_o (pick_idx)
    );

    assign busy_stb = m_cyc_i[grant_q] & m_stb_i[grant_q];

    // ---------------- state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= IW'(NUM_MASTERS - 1);   // master 0 wins first
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_idx;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!m_cyc_i[grant_q]) begin
                    state_d = ST_IDLE;
                    last_d  = grant_q;
                end else if (timeout_hit) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
                last_d  = grant_q;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_dat_o = '0;
        s_adr_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        m_dat_o = '0;
        if (state_q == ST_BUSY) begin
            s_cyc_o = m_cyc_i[grant_q];
            s_stb_o = busy_stb;
            if (m_cyc_i[grant_q]) begin
                s_we_o  = m_we_i[grant_q];
                s_sel_o = m_sel_i[int'(grant_q)*RAMBUS_SEL_W +: RAMBUS_SEL_W];
                s_dat_o = m_dat_i[int'(grant_q)*RAMBUS_DATA_W +: RAMBUS_DATA_W];
                s_adr_o = m_adr_i[int'(grant_q)*ADDR_W +: ADDR_W];
            end
            // A master that already dropped cyc never sees a late ack.
            m_ack_o[grant_q] = s_ack_i & m_cyc_i[grant_q];
            m_err_o[grant_q] = timeout_hit;
            m_dat_o[int'(grant_q)*RAMBUS_DATA_W +: RAMBUS_DATA_W] = s_dat_i;
        end
    end

`ifdef RAMBUS_ARB_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES < 256) ? 8 : 16;

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            stalled;

    assign stalled     = (state_q == ST_BUSY) && busy_stb && !s_ack_i;
    // Fires during the TIMEOUT_CYCLES-th stalled cycle (count starts at 0).
    assign timeout_hit = stalled && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    // Holds while stb is low inside the cycle; clears on ack or leaving BUSY.
    always_comb begin
        to_cnt_d = '0;
        if (state_q == ST_BUSY && state_d == ST_BUSY && !s_ack_i)
            to_cnt_d = stalled ? to_cnt_q + 1'b1 : to_cnt_q;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) to_cnt_q <= '0;
        else          to_cnt_q <= to_cnt_d;
    end
`else
    // TIMEOUT_CYCLES has no effect without the timeout option; a hung slave
    // holds the grant indefinitely.
    logic [31:0] unused_timeout_cycles;
    assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
    assign timeout_hit = 1'b0;
`endif

endmodule
